// File: rtl/booth_mul_r4.sv
// Radix-4 (modified) Booth multiplier, signed or unsigned operands,
// two multiplier bits retired per clock with a start/busy/done handshake.
module booth_mul_r4 #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int W  = (N % 2 == 0) ? N + 2 : N + 1;
    localparam int K  = W / 2;
    localparam int CW = $clog2(K + 1);
    localparam int PW = 2 * N;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [W+1:0]  r_acc;
    logic [W:0]    r_q;
    logic [W-1:0]  r_m;
    logic [CW-1:0] r_cnt;

    logic [W+1:0]  w_m_ext;
    logic [W+1:0]  w_m2;
    logic [W+1:0]  w_pp;
    logic [W+1:0]  w_sum;
    logic [W+1:0]  w_acc_nx;
    logic [W:0]    w_q_nx;
    logic [PW-1:0] w_prod;
    logic          w_last;
    logic [W-1:0]  w_a_ext;
    logic [W-1:0]  w_b_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_last = (r_cnt == LAST);

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Extension bits are zero in unsigned mode so both modes share one signed datapath.
    assign w_a_ext = {{(W-N){signed_mode & a[N-1]}}, a};
    assign w_b_ext = {{(W-N){signed_mode & b[N-1]}}, b};

    assign w_m_ext = {{2{r_m[W-1]}}, r_m};
    assign w_m2    = {w_m_ext[W:0], 1'b0};

    always_comb begin
        w_pp = '0;
        case (r_q[2:0])
            3'b001, 3'b010: w_pp = w_m_ext;
            3'b011:         w_pp = w_m2;
            3'b100:         w_pp = -w_m2;
            3'b101, 3'b110: w_pp = -w_m_ext;
            default:        w_pp = '0;
        endcase
    end

    assign w_sum    = r_acc + w_pp;
    assign w_acc_nx = {{2{w_sum[W+1]}}, w_sum[W+1:2]};
    assign w_q_nx   = {w_sum[1:0], r_q[W:2]};
    assign w_prod   = PW'({w_acc_nx, w_q_nx[W:1]});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
            product <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_m   <= w_a_ext;
                r_q   <= {w_b_ext, 1'b0};
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == S_CALC) begin
                r_acc <= w_acc_nx;
                r_q   <= w_q_nx;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    product <= w_prod;
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_r4.sv
// Directed and regression bench for booth_mul_r4 at N=16 and N=5.
module tb_booth_mul_r4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sm = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] product;

    logic        start5 = 1'b0;
    logic        sm5 = 1'b0;
    logic [4:0]  a5 = '0;
    logic [4:0]  b5 = '0;
    logic        busy5;
    logic        done5;
    logic [9:0]  product5;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    booth_mul_r4 #(.N(16)) u16 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm),
        .a(a), .b(b), .busy(busy), .done(done), .product(product)
    );

    booth_mul_r4 #(.N(5)) u5 (
        .clk(clk), .rst(rst), .start(start5), .signed_mode(sm5),
        .a(a5), .b(b5), .busy(busy5), .done(done5), .product(product5)
    );

    // One operation on the N=16 instance; returns in IDLE one edge after done.
    task automatic run16(input logic m, input logic [15:0] x, input logic [15:0] y,
                         output logic [31:0] p, output int lat,
                         output int nbusy, output int nboth);
        @(negedge clk);
        sm = m; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; nbusy = 0; nboth = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy && done) nboth++;
        p = product;
        @(posedge clk); #1;
    endtask

    task automatic run5(input logic m, input logic [4:0] x, input logic [4:0] y,
                        output logic [9:0] p, output int lat,
                        output int nbusy, output int nboth);
        @(negedge clk);
        sm5 = m; a5 = x; b5 = y; start5 = 1'b1;
        @(posedge clk); #1;
        start5 = 1'b0;
        lat = 0; nbusy = 0; nboth = 0;
        while (!done5 && lat < 20) begin
            if (busy5) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy5 && done5) nboth++;
        p = product5;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h0011;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got=%b want=0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL reset_done got=%b want=0", done);
        end
        checks++;
        if (product !== 32'h0) begin
            errors++; $display("FAIL reset_product got=%h want=0", product);
        end
        checks++;
        if (product5 !== 10'h0 || busy5 !== 1'b0 || done5 !== 1'b0) begin
            errors++;
            $display("FAIL reset_n5 got p=%h busy=%b done=%b want 0/0/0",
                     product5, busy5, done5);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] p;
        int lat, nb, nx;
        run16(1'b1, 16'hFFFD, 16'h0007, p, lat, nb, nx);
        checks++;
        if (p !== 32'hFFFFFFEB) begin
            errors++; $display("FAIL basic_product got=%h want=ffffffeb", p);
        end
        checks++;
        if (lat !== 9) begin
            errors++; $display("FAIL basic_latency got=%0d want=9", lat);
        end
        checks++;
        if (nb !== 9) begin
            errors++; $display("FAIL basic_busy_cycles got=%0d want=9", nb);
        end
        checks++;
        if (nx !== 0) begin
            errors++; $display("FAIL basic_busy_done_overlap got=%0d want=0", nx);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || product !== 32'hFFFFFFEB) begin
            errors++;
            $display("FAIL basic_hold got done=%b p=%h want done=0 p=ffffffeb",
                     done, product);
        end
    endtask

    task automatic test_directed();
        logic        tm[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] ta[5] = '{16'h8000, 16'h8000, 16'h0000, 16'hFFFF, 16'h8000};
        logic [15:0] tb[5] = '{16'h8000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0002};
        logic [31:0] te[5] = '{32'h40000000, 32'hC0008000, 32'h00000000,
                               32'hFFFE0001, 32'h00010000};
        logic [31:0] p;
        int lat, nb, nx;
        for (int i = 0; i < 5; i++) begin
            run16(tm[i], ta[i], tb[i], p, lat, nb, nx);
            checks++;
            if (p !== te[i]) begin
                errors++;
                $display("FAIL directed_%0d m=%b a=%h b=%h got=%h want=%h",
                         i, tm[i], ta[i], tb[i], p, te[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int pulses;
        logic [31:0] got;
        @(negedge clk);
        sm = 1'b1; a = 16'd3; b = 16'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        got = '0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            a = 16'h7FFF; b = 16'h1234; sm = 1'b0;
            start = busy | done;
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                got = product;
            end
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL ignore_pulses got=%0d want=1", pulses);
        end
        checks++;
        if (got !== 32'd12) begin
            errors++; $display("FAIL ignore_product got=%h want=0000000c", got);
        end
        checks++;
        if (busy !== 1'b0 || product !== 32'd12) begin
            errors++;
            $display("FAIL ignore_not_queued got busy=%b p=%h want busy=0 p=c",
                     busy, product);
        end
    endtask

    task automatic test_back_to_back();
        int t[$];
        int wait_cyc;
        logic [31:0] got;
        got = '0;
        @(negedge clk);
        sm = 1'b1; a = 16'd2; b = 16'd3; start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                t.push_back(i);
                got = product;
            end
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (t.size() !== 3) begin
            errors++; $display("FAIL b2b_pulses got=%0d want=3", t.size());
        end
        for (int i = 1; i < t.size(); i++) begin
            checks++;
            if (t[i] - t[i-1] !== 11) begin
                errors++;
                $display("FAIL b2b_gap_%0d got=%0d want=11", i, t[i] - t[i-1]);
            end
        end
        checks++;
        if (got !== 32'd6) begin
            errors++; $display("FAIL b2b_product got=%h want=00000006", got);
        end
        wait_cyc = 0;
        while ((busy || done) && wait_cyc < 30) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        checks++;
        if (wait_cyc >= 30) begin
            errors++; $display("FAIL b2b_drain got=timeout want=idle");
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        logic [31:0] p;
        int lat, nb, nx;
        @(negedge clk);
        sm = 1'b1; a = 16'd7; b = 16'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
            errors++;
            $display("FAIL midreset_state got busy=%b done=%b p=%h want 0/0/0",
                     busy, done, product);
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL midreset_no_done got=%0d want=0", pulses);
        end
        run16(1'b1, 16'd5, 16'hFFFA, p, lat, nb, nx);
        checks++;
        if (p !== 32'hFFFFFFE2) begin
            errors++; $display("FAIL midreset_next got=%h want=ffffffe2", p);
        end
    endtask

    task automatic test_random16();
        logic [31:0] p;
        logic [31:0] exp;
        logic [15:0] x, y;
        longint ea, eb, pe;
        int lat, nb, nx;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 2000; i++) begin
                x = 16'($urandom);
                y = 16'($urandom);
                ea = (m == 1) ? longint'($signed(x)) : longint'({48'h0, x});
                eb = (m == 1) ? longint'($signed(y)) : longint'({48'h0, y});
                pe = ea * eb;
                exp = pe[31:0];
                run16(m[0], x, y, p, lat, nb, nx);
                checks++;
                if (p !== exp) begin
                    errors++;
                    $display("FAIL rand16 m=%0d a=%h b=%h got=%h want=%h",
                             m, x, y, p, exp);
                end
                checks++;
                if (lat !== 9 || nx !== 0) begin
                    errors++;
                    $display("FAIL rand16_timing got lat=%0d overlap=%0d want 9/0",
                             lat, nx);
                end
            end
        end
    endtask

    task automatic test_exhaustive5();
        logic [9:0] p;
        logic [9:0] exp;
        logic [4:0] x, y;
        int ea, eb, pe;
        int lat, nb, nx;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 32; i++) begin
                for (int j = 0; j < 32; j++) begin
                    x = 5'(i);
                    y = 5'(j);
                    ea = (m == 1) ? int'($signed(x)) : i;
                    eb = (m == 1) ? int'($signed(y)) : j;
                    pe = ea * eb;
                    exp = pe[9:0];
                    run5(m[0], x, y, p, lat, nb, nx);
                    checks++;
                    if (p !== exp) begin
                        errors++;
                        $display("FAIL exh5 m=%0d a=%h b=%h got=%h want=%h",
                                 m, x, y, p, exp);
                    end
                    checks++;
                    if (lat !== 3 || nb !== 3 || nx !== 0) begin
                        errors++;
                        $display("FAIL exh5_timing got lat=%0d busy=%0d ov=%0d want 3/3/0",
                                 lat, nb, nx);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random16();
        test_exhaustive5();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
